// File: rtl/download_ctrl_pkg.sv
// Shared FSM encodings, phase lengths and a counter-width helper for the download controller.
// Pure constants and functions; no latency, no flow control.
package download_ctrl_pkg;

    localparam logic [2:0] ST_RUN        = 3'd0;
    localparam logic [2:0] ST_PREP       = 3'd1;
    localparam logic [2:0] ST_LOAD       = 3'd2;
    localparam logic [2:0] ST_DRAIN      = 3'd3;
    localparam logic [2:0] ST_RESET_CORE = 3'd4;

    localparam int PREP_CYC  = 4;
    localparam int DRAIN_CYC = 8;

    // A counter for n distinct values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/download_ctrl_if.sv
// Downloader write port plus core-control/status outputs of the download controller.
// Wires only; writes are strobes with no backpressure.
interface download_ctrl_if;
    logic        mem_wr_en_i;
    logic [31:0] mem_wr_addr_i;
    logic        debug_en_o;
    logic        cpu_halt_o;
    logic        cpu_rst_n_o;
    logic [15:0] word_cnt_o;
    logic        dl_busy_o;
    logic        dl_done_o;
    logic        dl_err_o;

    modport master (
        input  mem_wr_en_i, mem_wr_addr_i,
        output debug_en_o, cpu_halt_o, cpu_rst_n_o, word_cnt_o,
               dl_busy_o, dl_done_o, dl_err_o
    );

    modport slave (
        output mem_wr_en_i, mem_wr_addr_i,
        input  debug_en_o, cpu_halt_o, cpu_rst_n_o, word_cnt_o,
               dl_busy_o, dl_done_o, dl_err_o
    );
endinterface

// File: rtl/download_ctrl_key_debounce.sv
// Synchronises and debounces the active-low key; emits a one-cycle press on the debounced 1->0 edge.
// Latency 2 sync cycles + DEBOUNCE_CYC stable cycles; no backpressure.
module key_debounce
    import download_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = cnt_w(DEBOUNCE_CYC);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                // Accept on the DEBOUNCE_CYC-th consecutive differing sample.
                level <= sync_2;
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/download_ctrl.sv
// Halts and resets the core while the UART downloader fills instruction memory, then restarts it.
// Outputs registered (1 cycle after decision); downloader writes are never stalled, only counted and checked.
module download_ctrl
    import download_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 1_000_000,
    parameter int IDLE_TIMEOUT_CYC = 50_000_000,
    parameter int RST_HOLD_CYC     = 16,
    parameter int MAX_WORDS        = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_dl_n,
    download_ctrl_if.master dl
);
    localparam int IW = cnt_w(IDLE_TIMEOUT_CYC);
    localparam int PW = cnt_w((RST_HOLD_CYC > DRAIN_CYC) ? RST_HOLD_CYC : DRAIN_CYC);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [IW-1:0] idle_tmr;
    logic [PW-1:0] ph_tmr;
    logic          press;
    logic          wr;
    logic          from_dl;
    logic [15:0]   word_cnt;
    logic          err;
    logic          debug_en;
    logic          cpu_halt;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_dl_n),
        .press (press)
    );

    assign wr = dl.mem_wr_en_i && (state == ST_LOAD || state == ST_DRAIN);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:        if (press) state_nxt = ST_PREP;
            ST_PREP:       if (ph_tmr == PW'(PREP_CYC - 1)) state_nxt = ST_LOAD;
            ST_LOAD:       if (press || (idle_tmr == IW'(IDLE_TIMEOUT_CYC - 1) && word_cnt != 16'd0))
                               state_nxt = ST_DRAIN;
            ST_DRAIN:      if (ph_tmr == PW'(DRAIN_CYC - 1)) state_nxt = ST_RESET_CORE;
            ST_RESET_CORE: if (ph_tmr == PW'(RST_HOLD_CYC - 1)) state_nxt = ST_RUN;
            default:       state_nxt = ST_RESET_CORE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET_CORE;
            ph_tmr    <= '0;
            idle_tmr  <= '0;
            from_dl   <= 1'b0;
            word_cnt  <= 16'd0;
            err       <= 1'b0;
            debug_en  <= 1'b0;
            cpu_halt  <= 1'b1;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                ph_tmr   <= '0;
                idle_tmr <= '0;
            end else begin
                ph_tmr <= ph_tmr + 1'b1;
                if (wr)
                    idle_tmr <= '0;
                else if (idle_tmr != IW'(IDLE_TIMEOUT_CYC - 1))
                    idle_tmr <= idle_tmr + 1'b1;
            end

            if (state_nxt == ST_PREP && state != ST_PREP) begin
                word_cnt <= 16'd0;
                err      <= 1'b0;
            end else if (wr) begin
                // Capacity overflow and out-of-order addresses both flag the image as bad.
                if (word_cnt == 16'(MAX_WORDS))
                    err <= 1'b1;
                else
                    word_cnt <= word_cnt + 16'd1;
                if (dl.mem_wr_addr_i != {14'd0, word_cnt, 2'b00})
                    err <= 1'b1;
            end

            // Only a restart that followed a real download reports completion.
            if (state == ST_DRAIN && state_nxt == ST_RESET_CORE)
                from_dl <= 1'b1;
            else if (state_nxt == ST_RUN)
                from_dl <= 1'b0;

            done      <= (state == ST_RESET_CORE) && (state_nxt == ST_RUN) && from_dl;
            debug_en  <= (state_nxt == ST_LOAD);
            cpu_halt  <= (state_nxt != ST_RUN);
            cpu_rst_n <= (state_nxt == ST_RUN);
            busy      <= (state_nxt != ST_RUN);
        end
    end

    assign dl.debug_en_o  = debug_en;
    assign dl.cpu_halt_o  = cpu_halt;
    assign dl.cpu_rst_n_o = cpu_rst_n;
    assign dl.word_cnt_o  = word_cnt;
    assign dl.dl_busy_o   = busy;
    assign dl.dl_done_o   = done;
    assign dl.dl_err_o    = err;
endmodule

// File: tb/tb_download_ctrl.sv
// Directed bench for download_ctrl with short debounce/timeout parameters.
module tb_download_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic key_dl_n;
    int   ncmp     = 0;
    int   nfail    = 0;
    int   done_cnt = 0;
    int   n;

    download_ctrl_if dl();

    download_ctrl #(
        .DEBOUNCE_CYC     (8),
        .IDLE_TIMEOUT_CYC (100),
        .RST_HOLD_CYC     (16),
        .MAX_WORDS        (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_dl_n (key_dl_n),
        .dl       (dl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (dl.dl_done_o === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr);
        dl.mem_wr_en_i   = 1'b1;
        dl.mem_wr_addr_i = addr;
        @(negedge clk);
        dl.mem_wr_en_i   = 1'b0;
    endtask

    task automatic press_to_load(input string tag);
        int k;
        k = 0;
        key_dl_n = 1'b0;
        while (dl.debug_en_o !== 1'b1 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk(tag, dl.debug_en_o, 1'b1);
        key_dl_n = 1'b1;
    endtask

    task automatic wait_drain(output int k);
        k = 0;
        while (dl.debug_en_o === 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_run(output int k);
        k = 0;
        while (dl.dl_busy_o !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        key_dl_n         = 1'b1;
        dl.mem_wr_en_i   = 1'b0;
        dl.mem_wr_addr_i = 32'd0;
        cyc(3);
        chk("rst_cpu_rst_n", dl.cpu_rst_n_o, 0);
        chk("rst_halt",      dl.cpu_halt_o,  1);
        chk("rst_debug_en",  dl.debug_en_o,  0);
        chk("rst_word_cnt",  dl.word_cnt_o,  0);
        chk("rst_err",       dl.dl_err_o,    0);
        chk("rst_done",      dl.dl_done_o,   0);
        chk("rst_busy",      dl.dl_busy_o,   1);

        // Core release exactly 16 cycles after reset deassertion.
        rst_n = 1'b1;
        cyc(15);
        chk("rel_hold_15", dl.cpu_rst_n_o, 0);
        cyc(1);
        chk("rel_16_rst_n", dl.cpu_rst_n_o, 1);
        chk("rel_16_busy",  dl.dl_busy_o,   0);
        chk("rel_16_halt",  dl.cpu_halt_o,  0);
        cyc(2);
        chk("rel_no_done", done_cnt, 0);

        // Normal three-word download ending on idle timeout.
        press_to_load("dl3_enter_load");
        chk("dl3_load_wc",   dl.word_cnt_o,  0);
        chk("dl3_load_halt", dl.cpu_halt_o,  1);
        wr(32'h0); wr(32'h4); wr(32'h8);
        chk("dl3_wc",  dl.word_cnt_o, 3);
        chk("dl3_err", dl.dl_err_o,   0);
        wait_drain(n);
        chk("dl3_idle_cycles", n, 100);
        chk("dl3_drain_halt",  dl.cpu_halt_o,  1);
        chk("dl3_drain_rst",   dl.cpu_rst_n_o, 0);
        wait_run(n);
        chk("dl3_drain_reset_cycles", n, 24);
        chk("dl3_done_pulse", dl.dl_done_o, 1);
        cyc(1);
        chk("dl3_done_end", dl.dl_done_o, 0);
        chk("dl3_run_wc",   dl.word_cnt_o, 3);
        chk("dl3_run_err",  dl.dl_err_o,   0);
        chk("dl3_done_cnt", done_cnt, 1);

        // First write at the wrong address.
        press_to_load("bad_enter_load");
        wr(32'h8);
        chk("bad_err", dl.dl_err_o,   1);
        chk("bad_wc",  dl.word_cnt_o, 1);
        wait_drain(n);
        chk("bad_idle_cycles", n, 100);
        wait_run(n);
        chk("bad_done_pulse", dl.dl_done_o, 1);
        cyc(5);
        chk("bad_err_held", dl.dl_err_o,   1);
        chk("bad_wc_held",  dl.word_cnt_o, 1);

        // Overflow past capacity; an empty LOAD never times out.
        press_to_load("ovf_enter_load");
        chk("ovf_err_cleared", dl.dl_err_o,   0);
        chk("ovf_wc_cleared",  dl.word_cnt_o, 0);
        cyc(150);
        chk("ovf_empty_wait", dl.debug_en_o, 1);
        wr(32'h0); wr(32'h4); wr(32'h8); wr(32'hC);
        chk("ovf_full_err", dl.dl_err_o,   0);
        chk("ovf_full_wc",  dl.word_cnt_o, 4);
        wr(32'h10);
        chk("ovf_wc_sat", dl.word_cnt_o, 4);
        chk("ovf_err",    dl.dl_err_o,   1);
        // Key goes down late in LOAD so the debounced press lands in DRAIN.
        n = 0;
        while (dl.debug_en_o === 1'b1 && n < 400) begin
            if (n == 95) key_dl_n = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("ovf_idle_cycles", n, 100);
        wait_run(n);
        chk("drain_press_ignored", n, 24);
        key_dl_n = 1'b1;
        cyc(30);
        chk("drain_press_not_queued", dl.dl_busy_o,  0);
        chk("ovf_run_wc",             dl.word_cnt_o, 4);
        chk("ovf_run_err",            dl.dl_err_o,   1);
        chk("ovf_done_cnt",           done_cnt,      3);

        // Short glitch must not register as a press.
        key_dl_n = 1'b0;
        cyc(3);
        key_dl_n = 1'b1;
        cyc(30);
        chk("glitch_busy",     dl.dl_busy_o,  0);
        chk("glitch_debug_en", dl.debug_en_o, 0);

        // Reset in the middle of LOAD aborts at once.
        press_to_load("abort_enter_load");
        wr(32'h0); wr(32'h4);
        chk("abort_pre_wc", dl.word_cnt_o, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_wc",       dl.word_cnt_o,  0);
        chk("abort_debug_en", dl.debug_en_o,  0);
        chk("abort_busy",     dl.dl_busy_o,   1);
        chk("abort_cpu_rst",  dl.cpu_rst_n_o, 0);
        cyc(3);
        rst_n = 1'b1;
        wait_run(n);
        chk("abort_release_cycles", n, 16);
        chk("abort_no_done_now", dl.dl_done_o, 0);
        cyc(2);
        chk("abort_no_done", done_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
